// File: rtl/tcni_rx_if.sv
// Router-local-port receive handshake and memory write port of the TCNI receive DMA.
// The slave modport is the DMA engine's view; the master modport is the network/memory side.
interface tcni_rx_if;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic        mem_busy;

    modport slave (
        input  rx_data, rx_valid, mem_busy,
        output rx_ready, mem_addr, mem_data, mem_we
    );

    modport master (
        output rx_data, rx_valid, mem_busy,
        input  rx_ready, mem_addr, mem_data, mem_we
    );
endinterface

// File: rtl/tcni_rx.sv
// TCNI receive DMA: writes router packets into a ring of fixed-size memory slots.
// Optional macro TCNI_RX_TIMESTAMP_EN stores the header-arrival cycle in each slot's last word.
module tcni_rx #(
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned SLOT_WORDS = 64,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_8000
) (
    input  logic       clock,
    input  logic       reset,
    tcni_rx_if.slave   bus,
    input  logic       slot_release,
    output logic       rx_irq,
    output logic [4:0] rx_count,
    output logic       rx_trunc
);
    localparam int unsigned PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned WW = $clog2(SLOT_WORDS) + 1;
`ifdef TCNI_RX_TIMESTAMP_EN
    localparam int unsigned DATA_END = SLOT_WORDS - 1;
`else
    localparam int unsigned DATA_END = SLOT_WORDS;
`endif
    localparam logic [WW-1:0] LAST_DATA_IDX = WW'(DATA_END - 1);
    localparam logic [4:0]    FULL_COUNT    = 5'(NUM_SLOTS);

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_LEN     = 3'd1,
        RX_PAYLOAD = 3'd2,
        RX_DROP    = 3'd3,
        RX_COMMIT  = 3'd4
    } state_t;

    function automatic logic [31:0] word_addr(input logic [PW-1:0] slot, input logic [WW-1:0] idx);
        word_addr = BASE_ADDR + (32'(slot) * 32'(SLOT_WORDS) + 32'(idx)) * 32'd4;
    endfunction

    state_t        state_q, state_d;
    logic [PW-1:0] wr_slot_q, wr_slot_d;
    logic [PW-1:0] rd_slot_q, rd_slot_d;
    logic [4:0]    count_q, count_d;
    logic          trunc_q, trunc_d;
    logic          irq_q, irq_d;
    logic          ready_q, ready_d;
    logic [15:0]   remain_q, remain_d;
    logic [WW-1:0] widx_q, widx_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_data_q, mem_data_d;
`ifdef TCNI_RX_TIMESTAMP_EN
    logic [31:0]   ts_q, ts_d;
    logic [31:0]   hdr_ts_q, hdr_ts_d;
`endif

    logic rx_ready_s, accept_s, pending_s, release_s, commit_s, trunc_set_s;

    // Next-state, datapath and slot bookkeeping.
    always_comb begin
        pending_s   = mem_we_q & bus.mem_busy;
        rx_ready_s  = ready_q & ~bus.mem_busy;
        accept_s    = bus.rx_valid & rx_ready_s;
        release_s   = slot_release & (count_q != 5'd0);
        commit_s    = 1'b0;
        trunc_set_s = 1'b0;
        state_d     = state_q;
        wr_slot_d   = wr_slot_q;
        remain_d    = remain_q;
        widx_d      = widx_q;
        // A write the memory refused stays on the bus unchanged.
        mem_we_d    = pending_s;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
`ifdef TCNI_RX_TIMESTAMP_EN
        ts_d        = ts_q + 32'd1;
        hdr_ts_d    = hdr_ts_q;
`endif
        case (state_q)
            RX_IDLE: begin
                if (accept_s) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = word_addr(wr_slot_q, WW'(0));
                    mem_data_d = bus.rx_data;
                    state_d    = RX_LEN;
`ifdef TCNI_RX_TIMESTAMP_EN
                    hdr_ts_d   = ts_q;
`endif
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_LEN: begin
                if (accept_s) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = word_addr(wr_slot_q, WW'(1));
                    mem_data_d = bus.rx_data;
                    remain_d   = bus.rx_data[15:0];
                    widx_d     = WW'(2);
                    state_d    = (bus.rx_data[15:0] == 16'd0) ? RX_COMMIT : RX_PAYLOAD;
                end else begin
                    state_d = RX_LEN;
                end
            end
            RX_PAYLOAD: begin
                if (accept_s) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = word_addr(wr_slot_q, widx_q);
                    mem_data_d = bus.rx_data;
                    remain_d   = remain_q - 16'd1;
                    widx_d     = widx_q + WW'(1);
                    if (remain_q == 16'd1) begin
                        state_d = RX_COMMIT;
                    end else if (widx_q == LAST_DATA_IDX) begin
                        state_d     = RX_DROP;
                        trunc_set_s = 1'b1;
                    end else begin
                        state_d = RX_PAYLOAD;
                    end
                end else begin
                    state_d = RX_PAYLOAD;
                end
            end
            RX_DROP: begin
                if (accept_s) begin
                    remain_d = remain_q - 16'd1;
                    state_d  = (remain_q == 16'd1) ? RX_COMMIT : RX_DROP;
                end else begin
                    state_d = RX_DROP;
                end
            end
            RX_COMMIT: begin
`ifdef TCNI_RX_TIMESTAMP_EN
                // The stamp write must wait until the last payload write has left the bus.
                if (!pending_s) begin
                    commit_s   = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = word_addr(wr_slot_q, WW'(SLOT_WORDS - 1));
                    mem_data_d = hdr_ts_q;
                    wr_slot_d  = wr_slot_q + PW'(1);
                    state_d    = RX_IDLE;
                end else begin
                    state_d = RX_COMMIT;
                end
`else
                commit_s  = 1'b1;
                wr_slot_d = wr_slot_q + PW'(1);
                state_d   = RX_IDLE;
`endif
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase

        count_d   = count_q + 5'(commit_s) - 5'(release_s);
        rd_slot_d = release_s ? (rd_slot_q + PW'(1)) : rd_slot_q;
        if (trunc_set_s) begin
            trunc_d = 1'b1;
        end else if (release_s) begin
            trunc_d = 1'b0;
        end else begin
            trunc_d = trunc_q;
        end
        irq_d = (count_d != 5'd0);

        // Readiness is registered from the next state; memory busy gates it combinationally.
        case (state_d)
            RX_IDLE:    ready_d = (count_d < FULL_COUNT);
            RX_LEN:     ready_d = 1'b1;
            RX_PAYLOAD: ready_d = 1'b1;
            RX_DROP:    ready_d = 1'b1;
            RX_COMMIT:  ready_d = 1'b0;
            default:    ready_d = 1'b0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= RX_IDLE;
            wr_slot_q  <= '0;
            rd_slot_q  <= '0;
            count_q    <= 5'd0;
            trunc_q    <= 1'b0;
            irq_q      <= 1'b0;
            ready_q    <= 1'b0;
            remain_q   <= 16'd0;
            widx_q     <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 32'd0;
            mem_data_q <= 32'd0;
`ifdef TCNI_RX_TIMESTAMP_EN
            ts_q       <= 32'd0;
            hdr_ts_q   <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            wr_slot_q  <= wr_slot_d;
            rd_slot_q  <= rd_slot_d;
            count_q    <= count_d;
            trunc_q    <= trunc_d;
            irq_q      <= irq_d;
            ready_q    <= ready_d;
            remain_q   <= remain_d;
            widx_q     <= widx_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
`ifdef TCNI_RX_TIMESTAMP_EN
            ts_q       <= ts_d;
            hdr_ts_q   <= hdr_ts_d;
`endif
        end
    end

    assign bus.rx_ready = rx_ready_s;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign rx_irq       = irq_q;
    assign rx_count     = count_q;
    assign rx_trunc     = trunc_q;
endmodule

// File: tb/tb_tcni_rx.sv
// Bench for tcni_rx: table-driven packet rows, hand-written corner sequences and random
// traffic, all checked against a slot-level model of the receive buffer.
module tb_tcni_rx;
    localparam int          NS   = 4;
    localparam int          SWD  = 64;
    localparam logic [31:0] BASE = 32'h0000_8000;
`ifdef TCNI_RX_TIMESTAMP_EN
    localparam int          CAP  = SWD - 3;
`else
    localparam int          CAP  = SWD - 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       slot_release = 1'b0;
    logic       rx_irq;
    logic [4:0] rx_count;
    logic       rx_trunc;
    logic       busy_hand = 1'b0;
    logic       busy_rand = 1'b0;
    logic       busy_en = 1'b0;
    logic       gap_en = 1'b0;
    logic [31:0] cyc;
    logic [31:0] last_acc_cyc = 32'd0;
    logic [31:0] first_addr = 32'd0;

    int tests = 0;
    int failed = 0;

    // Slot-level model state
    int m_wr = 0;
    int m_count = 0;
    bit m_trunc = 1'b0;
    logic [63:0] eq[$];
    logic [63:0] wq[$];

    typedef struct {
        logic [31:0] hdr;
        logic [31:0] lword;
        int          n_rel;
        logic [31:0] exp_addr0;
        logic [4:0]  exp_count;
        logic        exp_trunc;
    } vec_t;
    vec_t tbl [6];

    tcni_rx_if bif();

    tcni_rx #(.NUM_SLOTS(NS), .SLOT_WORDS(SWD), .BASE_ADDR(BASE)) dut (
        .clock(clk), .reset(rst_n), .bus(bif),
        .slot_release(slot_release), .rx_irq(rx_irq),
        .rx_count(rx_count), .rx_trunc(rx_trunc)
    );

    assign bif.mem_busy = busy_hand | (busy_en & busy_rand);

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 32'd0;
        else        cyc <= cyc + 32'd1;
    end

    always @(posedge clk) begin
        #1 busy_rand = ($urandom_range(0, 2) == 0);
    end

    // Completed memory writes, observed mid-cycle
    always @(negedge clk) begin
        if (rst_n && bif.mem_we && !bif.mem_busy) wq.push_back({bif.mem_addr, bif.mem_data});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pay(input logic [31:0] h, input int i);
        return h ^ (32'h5A00_0000 + 32'(i));
    endfunction

    task automatic send_flit(input logic [31:0] d);
        int n;
        bit acc;
        if (gap_en && $urandom_range(0, 3) == 0) begin
            bif.rx_valid = 1'b0;
            @(posedge clk); #1;
        end
        bif.rx_valid = 1'b1;
        bif.rx_data  = d;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            if (bif.rx_ready) begin
                acc = 1'b1;
                last_acc_cyc = cyc;
            end
            n++;
            @(posedge clk); #1;
        end
        bif.rx_valid = 1'b0;
        if (!acc) begin
            tests++;
            failed++;
            $display("FAIL accept_timeout: flit %h not accepted within 200 cycles", d);
        end
    endtask

    task automatic release_pulse();
        slot_release = 1'b1;
        @(posedge clk); #1;
        slot_release = 1'b0;
        if (m_count > 0) begin
            m_count--;
            m_trunc = 1'b0;
        end
    endtask

    // Sends one packet and records the writes the model expects from it.
    task automatic send_packet(input logic [31:0] hdr, input logic [31:0] lword, input bit rel_end);
        int          len;
        int          nw;
        logic [31:0] base;
        logic [31:0] hc;
        len  = int'(lword[15:0]);
        base = BASE + 32'(m_wr) * 32'(SWD) * 32'd4;
        nw   = (len > CAP) ? CAP : len;
        eq.push_back({base, hdr});
        eq.push_back({base + 32'd4, lword});
        for (int i = 0; i < nw; i++) eq.push_back({base + 32'(4 * (2 + i)), pay(hdr, i)});
        send_flit(hdr);
        hc = last_acc_cyc;
        send_flit(lword);
        for (int i = 0; i < len; i++) send_flit(pay(hdr, i));
`ifdef TCNI_RX_TIMESTAMP_EN
        eq.push_back({base + 32'(4 * (SWD - 1)), hc});
`else
        hc = 32'd0;
`endif
        if (rel_end) begin
            slot_release = 1'b1;
            @(posedge clk); #1;
            slot_release = 1'b0;
        end
        m_wr = (m_wr + 1) % NS;
        if (len > CAP) m_trunc = 1'b1;
        if (rel_end && m_count > 0) m_trunc = 1'b0;
        else m_count++;
    endtask

    task automatic check_packet();
        int n;
        int k;
        n = 0;
        while (wq.size() < eq.size() && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) begin @(posedge clk); #1; end
        chk("write_count", 64'(wq.size()), 64'(eq.size()));
        k = (wq.size() < eq.size()) ? wq.size() : eq.size();
        for (int i = 0; i < k; i++) chk($sformatf("write[%0d] addr_data", i), wq[i], eq[i]);
        first_addr = (wq.size() > 0) ? wq[0][63:32] : 32'hFFFF_FFFF;
        wq.delete();
        eq.delete();
    endtask

    task automatic check_state();
        chk("rx_count", 64'(rx_count), 64'(m_count));
        chk("rx_irq", 64'(rx_irq), 64'(m_count != 0));
        chk("rx_trunc", 64'(rx_trunc), 64'(m_trunc));
    endtask

    task automatic run_row(input int i);
        for (int r = 0; r < tbl[i].n_rel; r++) release_pulse();
        if (tbl[i].n_rel > 0) chk("rel_count", 64'(rx_count), 64'(m_count));
        send_packet(tbl[i].hdr, tbl[i].lword, 1'b0);
        check_packet();
        chk($sformatf("row%0d slot_addr", i), 64'(first_addr), 64'(tbl[i].exp_addr0));
        chk($sformatf("row%0d rx_count", i), 64'(rx_count), 64'(tbl[i].exp_count));
        chk($sformatf("row%0d rx_irq", i), 64'(rx_irq), 64'(tbl[i].exp_count != 5'd0));
        chk($sformatf("row%0d rx_trunc", i), 64'(rx_trunc), 64'(tbl[i].exp_trunc));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        tbl[0] = '{32'h0003_0001, 32'd3,          0, 32'h0000_8000, 5'd1, 1'b0};
        tbl[1] = '{32'h0004_0002, 32'd0,          0, 32'h0000_8100, 5'd2, 1'b0};
        tbl[2] = '{32'h0005_0003, 32'd5,          0, 32'h0000_8200, 5'd3, 1'b0};
        tbl[3] = '{32'h0006_0004, 32'd2,          0, 32'h0000_8300, 5'd4, 1'b0};
        tbl[4] = '{32'h0008_0006, 32'd70,         4, 32'h0000_8100, 5'd1, 1'b1};
        tbl[5] = '{32'h0009_0007, 32'hFFFF_0002,  1, 32'h0000_8200, 5'd1, 1'b0};

        bif.rx_valid = 1'b0;
        bif.rx_data  = 32'd0;
        #3;
        chk("reset rx_ready", 64'(bif.rx_ready), 64'd0);
        chk("reset mem_we", 64'(bif.mem_we), 64'd0);
        chk("reset mem_addr", 64'(bif.mem_addr), 64'd0);
        chk("reset mem_data", 64'(bif.mem_data), 64'd0);
        chk("reset rx_irq", 64'(rx_irq), 64'd0);
        chk("reset rx_count", 64'(rx_count), 64'd0);
        chk("reset rx_trunc", 64'(rx_trunc), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_row(i);

        // Buffer full: the fifth header must wait for a release
        bif.rx_data  = 32'h0007_0005;
        bif.rx_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("full rx_ready", 64'(bif.rx_ready), 64'd0);
            @(posedge clk); #1;
        end
        chk("full no_write", 64'(wq.size()), 64'd0);
        slot_release = 1'b1;
        @(posedge clk); #1;
        slot_release = 1'b0;
        bif.rx_valid = 1'b0;
        m_count--;
        @(negedge clk);
        chk("release rx_ready", 64'(bif.rx_ready), 64'd1);
        @(posedge clk); #1;
        send_packet(32'h0007_0005, 32'd1, 1'b0);
        check_packet();
        chk("fifth slot_addr", 64'(first_addr), 64'h8000);
        check_state();

        for (int i = 4; i < 6; i++) run_row(i);

        // Memory busy for three cycles in the middle of a payload
        fork
            send_packet(32'h000A_0008, 32'd4, 1'b0);
            begin
                int n;
                n = 0;
                while (wq.size() < 3 && n < 100) begin @(negedge clk); n++; end
                @(posedge clk); #1;
                busy_hand = 1'b1;
                @(negedge clk);
                a = bif.mem_addr;
                d = bif.mem_data;
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge clk);
                    chk("busy mem_we", 64'(bif.mem_we), 64'd1);
                    chk("busy mem_addr", 64'(bif.mem_addr), 64'(a));
                    chk("busy mem_data", 64'(bif.mem_data), 64'(d));
                    chk("busy rx_ready", 64'(bif.rx_ready), 64'd0);
                end
                @(posedge clk); #1;
                busy_hand = 1'b0;
            end
        join
        check_packet();
        chk("busy slot_addr", 64'(first_addr), 64'h8300);
        check_state();

        // Commit and release in the same cycle with two slots full
        send_packet(32'h000B_0009, 32'd1, 1'b1);
        check_packet();
        chk("coincident slot_addr", 64'(first_addr), 64'h8000);
        chk("coincident rx_count", 64'(rx_count), 64'd2);
        send_packet(32'h000C_000A, 32'd2, 1'b0);
        check_packet();
        chk("after coincident slot_addr", 64'(first_addr), 64'h8100);
        check_state();

        // Reset in the middle of a payload
        send_flit(32'h000D_000B);
        send_flit(32'd5);
        send_flit(pay(32'h000D_000B, 0));
        send_flit(pay(32'h000D_000B, 1));
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midreset rx_ready", 64'(bif.rx_ready), 64'd0);
        chk("midreset mem_we", 64'(bif.mem_we), 64'd0);
        chk("midreset mem_addr", 64'(bif.mem_addr), 64'd0);
        chk("midreset mem_data", 64'(bif.mem_data), 64'd0);
        chk("midreset rx_irq", 64'(rx_irq), 64'd0);
        chk("midreset rx_count", 64'(rx_count), 64'd0);
        chk("midreset rx_trunc", 64'(rx_trunc), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wq.delete();
        eq.delete();
        m_wr = 0;
        m_count = 0;
        m_trunc = 1'b0;
        send_packet(32'h000E_000C, 32'd3, 1'b0);
        check_packet();
        chk("post-reset slot_addr", 64'(first_addr), 64'h8000);
        check_state();

        // Random traffic with memory stalls and valid gaps
        busy_en = 1'b1;
        gap_en  = 1'b1;
        for (int p = 0; p < 30; p++) begin
            logic [15:0] len;
            if (m_count == NS || $urandom_range(0, 2) == 0) release_pulse();
            if ($urandom_range(0, 4) == 0) len = 16'($urandom_range(55, 70));
            else                           len = 16'($urandom_range(0, 10));
            send_packet($urandom, {16'($urandom), len}, 1'b0);
            check_packet();
            check_state();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/tcni_rx.md
Name: tcni_rx

Overview:
Receive-side companion of the time-controlled network interface. Consumes packets arriving from the router local port and writes them by DMA into a slotted receive buffer in memory. Posts a completion notification per packet and applies backpressure toward the network when all slots are occupied. Sits between the router local output and the memory write port; the processor core only reads and releases slots.

Parameters:
NUM_SLOTS, 4, number of receive slots in the buffer (power of two, 2..16)
SLOT_WORDS, 64, words per slot including the length word (power of two, >=4)
BASE_ADDR, 32'h0000_8000, byte address of slot 0; slot k at BASE_ADDR + k*SLOT_WORDS*4

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
rx_data  input  32  flit from router
rx_valid  input  1  flit present
rx_ready  output  1  flit accepted when rx_valid && rx_ready
mem_addr  output  32  byte address of write
mem_data  output  32  write data
mem_we  output  1  write strobe, held while mem_busy
mem_busy  input  1  memory not accepting; write retried next cycle
slot_release  input  1  one-cycle pulse: core frees oldest full slot
rx_irq  output  1  level, high while any slot holds an unread packet
rx_count  output  5  number of full slots (0..NUM_SLOTS)
rx_trunc  output  1  sticky: a packet was truncated; cleared by slot_release

Behaviour:
- Packet format: flit0 header {src[31:16], dst[15:0]}; flit1 payload length L in words; then L payload flits.
- Slot layout: word0 = header, word1 = L as received, words 2..SLOT_WORDS-1 = payload.
- Reset values: rx_ready=0, mem_we=0, mem_addr=0, mem_data=0, rx_irq=0, rx_count=0, rx_trunc=0; write and read slot pointers 0; FSM in RX_IDLE.
- FSM:
  - RX_IDLE: rx_ready=1 iff rx_count<NUM_SLOTS. On an accepted flit, write it to word0 of the write slot -> RX_LEN.
  - RX_LEN: accept flit, write to word1, latch L. L==0 -> RX_COMMIT, else -> RX_PAYLOAD.
  - RX_PAYLOAD: accept flit, write to the next word, decrement remaining count. Once the word index reaches SLOT_WORDS with payload remaining -> RX_DROP. Last flit -> RX_COMMIT.
  - RX_DROP: rx_ready=1, flits discarded (no mem_we) until L total payload flits are consumed -> RX_COMMIT; set rx_trunc.
  - RX_COMMIT (1 cycle, rx_ready=0): advance the write slot pointer modulo NUM_SLOTS, rx_count+1 -> RX_IDLE.
- Latency: a flit accepted in cycle N drives mem_we/addr/data in cycle N+1 (registered).
- rx_ready=0 whenever mem_busy=1 or a write is pending, so at most one write is outstanding. mem_we stays asserted with stable addr/data until a cycle with mem_busy=0.
- slot_release: rx_count-1 and read pointer+1 modulo NUM_SLOTS. It is ignored when rx_count==0.
- Simultaneous COMMIT and slot_release in the same cycle: rx_count unchanged, both pointers advance.
- Full: when rx_count==NUM_SLOTS, no new header is accepted in RX_IDLE. A packet already in progress always completes.
- rx_irq = (rx_count != 0).
- Reset mid-packet: everything returns to reset values. Any partial slot is abandoned and not counted.
- Pointer arithmetic is unsigned modulo NUM_SLOTS. The length counter is 16 bits; L uses rx_data[15:0], upper bits are ignored.

Optional Feature:
TCNI_RX_TIMESTAMP_EN
- Defined: a 32-bit free-running cycle counter (reset 0, wraps) runs continuously. Its value at header acceptance is written to the last word of the slot (SLOT_WORDS-1) during RX_COMMIT, which adds one write cycle. Payload capacity shrinks to SLOT_WORDS-3 words; truncation threshold shifts accordingly.
- Undefined: no counter, no extra write, payload capacity SLOT_WORDS-2.

Test Plan:
- Single packet, header 32'h0003_0001, L=3, payload A,B,C, mem_busy=0 -> writes to 0x8000..0x8010 = {hdr,3,A,B,C}; rx_count=1, rx_irq=1 one cycle after the last write.
- Four packets with no release (NUM_SLOTS=4) -> rx_count=4, rx_ready=0 on the fifth header. A slot_release pulse -> rx_ready=1 next cycle; the fifth packet lands in slot 0 at 0x8000.
- L=70 with SLOT_WORDS=64 -> 62 payload words written, 8 flits drained with no mem_we, rx_trunc=1, rx_count=1; rx_trunc clears on slot_release.
- mem_busy held high 3 cycles during payload -> mem_we/addr/data stable, rx_ready=0 for those cycles, no flit lost or duplicated.
- COMMIT coincident with slot_release while rx_count=2 -> rx_count stays 2, both pointers advance. Reset low mid-payload -> all outputs return to 0 asynchronously; next packet writes slot 0.
- TCNI_RX_TIMESTAMP_EN defined, header accepted at cycle 100 after reset -> word 0x80FC of slot 0 = 100.
